seven_segment_scan_driver: RTL and testbench
============================================

// Module: seven_segment_scan_driver
// PURPOSE
//  Consumer end of the 7-bit Display pattern interface produced by the seven-segment decoders.
//  - Captures DIGITS patterns through a Load/Ready handshake.
//  - Time-multiplexes them onto one shared segment bus, with one-hot digit enables.
//  - Board-level output stage: sits between the decoder bank and the 7-seg pins.
// PARAMETERS
//  DIGITS    4      number of digits scanned; legal 1..8
//  PRESCALE  50000  Clk cycles per digit slot; must be > BLANK
//  BLANK     16     cycles at start of each slot with segments and enables forced off (anti-ghost); 0 allowed
// PORTS
//  Clk         in   1          system clock; all logic is on the rising edge
//  Resetn      in   1          asynchronous, active-low reset
//  Load        in   1          offer new pattern set; accepted on a cycle with Load && Ready
//  Patterns    in   7*DIGITS   digit k = Patterns[7k+6:7k]; bit0=a..bit6=g, active-high (decoder encoding)
//  Ready       out  1          high = shadow register free; Load is accepted
//  Segments    out  7          shared segment bus, active-high
//  DigitEn     out  DIGITS     one-hot digit enable, active-high
//  FrameStart  out  1          one-cycle pulse, registered with the first cycle of digit 0's slot
// BEHAVIOUR
//  - Reset (async assert, sync release): Cnt=0, Idx=0, Active=0, Shadow=0, Pending=0.
//    Outputs during reset: Ready=1, Segments=0, DigitEn=0, FrameStart=0.
//  - Cnt counts 0..PRESCALE-1, then wraps to 0.
//    - On wrap, Idx increments 0..DIGITS-1, then wraps to 0.
//    - A frame is DIGITS*PRESCALE cycles.
//  - Outputs are registered. On the edge after a cycle with counter state (Cnt, Idx):
//    - Cnt < BLANK  : Segments=0, DigitEn=0.
//    - Cnt >= BLANK : Segments=Active[Idx], DigitEn=(1<<Idx).
//    - FrameStart=1 iff Cnt==0 && Idx==0.
//    - Net effect: one-cycle latency from counter state to pins.
//  - Handshake:
//    - Load && Ready : Shadow<=Patterns, Pending<=1, and Ready=0 from the next cycle.
//    - Load while Ready=0 : ignored. Shadow is never overwritten.
//  - Commit happens only at the frame boundary (Cnt==PRESCALE-1 && Idx==DIGITS-1 && Pending):
//    - Active<=Shadow and Pending<=0; Ready=1 from the next cycle.
//    - No mid-frame tearing is possible.
//  - Simultaneous Load and commit in the same cycle: Ready is still 0, so the Load is ignored.
//  - Patterns is sampled only on the accept cycle; later changes have no effect.
//  - DIGITS==1: Idx stays 0, and every slot is a frame boundary.
//  - Reset mid-frame: all state clears immediately; the display blanks (Active=0).
//  - Ready = ~Pending, driven combinationally from the Pending register.
// CONFIGURATION
//  SEVENSEG_SCAN_DIM_EN defined:
//    - Adds input Brightness[3:0], sampled every cycle.
//    - Within the active window, segments/enables are on only while (Cnt-BLANK) < ((PRESCALE-BLANK)*(Brightness+1))>>4.
//    - Otherwise both are 0. Brightness=15 gives full on-time.
//    - Intermediate product width is sized so it cannot overflow.
//  Not defined: no Brightness port; the whole window after BLANK is on.
// TESTING (DIGITS=4, PRESCALE=8, BLANK=2)
//  - Reset: Resetn=0 mid-scan -> Segments=0, DigitEn=0, Ready=1 immediately.
//    After release, FrameStart pulses once every 32 cycles.
//  - Load=1 with Patterns={7'h06,7'h5B,7'h4F,7'h66} mid-frame:
//    - Ready=0 next cycle.
//    - Display stays blank until the frame boundary.
//    - Next frame, digit0 shows 7'h66 with DigitEn=4'b0001 for 6 of 8 cycles.
//    - Digit3 shows 7'h06 with DigitEn=4'b1000.
//  - Second Load while Ready=0 with all 7'h7F -> ignored; frame shows the first set.
//  - Load asserted exactly on the commit cycle -> not accepted.
//    Ready rises one cycle later; a Load then is accepted.
//  - Blanking: the first 2 cycles of every slot show Segments=0, DigitEn=0.
//    DigitEn is never multi-hot, checked for every cycle.
//  - DIM_EN with Brightness=7 -> 3 on-cycles per slot ((6*8)>>4), then off for the rest of the slot.

Source files
------------

// File: rtl/seven_segment_scan_driver.sv
// Scan driver for a multiplexed seven-segment display: double-buffered pattern capture,
// blanked digit slots and frame-boundary commit. Optional dimming via SEVENSEG_SCAN_DIM_EN.
module seven_segment_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic                  Clk,
    input  logic                  Resetn,
    input  logic                  Load,
    input  logic [7*DIGITS-1:0]   Patterns,
`ifdef SEVENSEG_SCAN_DIM_EN
    input  logic [3:0]            Brightness,
`endif
    output logic                  Ready,
    output logic [6:0]            Segments,
    output logic [DIGITS-1:0]     DigitEn,
    output logic                  FrameStart
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [7*DIGITS-1:0]   active_q, active_d;
    logic [7*DIGITS-1:0]   shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [6:0]            segments_q, segments_d;
    logic [DIGITS-1:0]     digit_en_q, digit_en_d;
    logic                  frame_start_q, frame_start_d;

    logic                  slot_end;
    logic                  frame_end;
    logic                  accept;
    logic                  commit;
    logic                  in_window;
    logic                  lit;
    logic [6:0]            cur_pattern;
    logic [DIGITS-1:0]     cur_onehot;

    // Load/Ready: a pattern set is taken on any cycle with Load && Ready; Ready stays low
    // until the held set is committed at the end of a frame, so the shadow is never overwritten.
    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        accept    = Load && !pending_q;
        commit    = frame_end && pending_q;
    end

    always_comb begin
        cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        shadow_d  = accept ? Patterns : shadow_q;
        active_d  = commit ? shadow_q : active_q;
        pending_d = pending_q;
        if (commit) begin
            pending_d = 1'b0;
        end else if (accept) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        cur_pattern = '0;
        cur_onehot  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_pattern   = active_q[7*k +: 7];
                cur_onehot[k] = 1'b1;
            end
        end
    end

    generate
        if (BLANK == 0) begin : g_no_blank
            assign in_window = 1'b1;
        end else begin : g_blank
            assign in_window = (cnt_q >= CW'(BLANK));
        end
    endgenerate

`ifdef SEVENSEG_SCAN_DIM_EN
    // Product carries 5 extra bits over the slot span so (span * 16) never overflows.
    localparam int SW = $clog2(PRESCALE + 1);
    localparam int PW = SW + 5;
    localparam logic [PW-1:0] SPAN = PW'(PRESCALE - BLANK);

    logic [PW-1:0] on_prod;
    logic [PW-1:0] on_offset;

    always_comb begin
        on_prod   = SPAN * PW'({1'b0, Brightness} + 5'd1);
        on_offset = PW'(cnt_q) - PW'(BLANK);
        lit       = in_window && (on_offset < (on_prod >> 4));
    end
`else
    assign lit = in_window;
`endif

    always_comb begin
        segments_d    = lit ? cur_pattern : 7'd0;
        digit_en_d    = lit ? cur_onehot : '0;
        frame_start_d = (cnt_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            segments_q    <= '0;
            digit_en_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            segments_q    <= segments_d;
            digit_en_q    <= digit_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign Ready      = ~pending_q;
    assign Segments   = segments_q;
    assign DigitEn    = digit_en_q;
    assign FrameStart = frame_start_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver (DIGITS=4, PRESCALE=8, BLANK=2); also covers the
// SEVENSEG_SCAN_DIM_EN build when that macro is defined.
module tb_seven_segment_scan_driver;
    localparam int DIGITS   = 4;
    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = DIGITS * PRESCALE;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        load = 1'b0;
    logic [27:0] patterns = '0;
    logic        ready;
    logic [6:0]  segments;
    logic [3:0]  digit_en;
    logic        frame_start;
`ifdef SEVENSEG_SCAN_DIM_EN
    logic [3:0]  brightness = 4'd15;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: time since reset plus the pattern buffers
    int          m_t;
    logic        m_pending;
    logic [27:0] m_shadow;
    logic [27:0] m_active;
    logic [12:0] exp_q[$];

    int lit66;
    int lit06;
    int lit_cnt;

    seven_segment_scan_driver #(
        .DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK(BLANK)
    ) dut (
        .Clk(clk),
        .Resetn(resetn),
        .Load(load),
        .Patterns(patterns),
`ifdef SEVENSEG_SCAN_DIM_EN
        .Brightness(brightness),
`endif
        .Ready(ready),
        .Segments(segments),
        .DigitEn(digit_en),
        .FrameStart(frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Asserts reset at a negedge, checks the immediate output values, releases at a later negedge.
    task automatic do_reset(input int hold);
        resetn = 1'b0;
        #1;
        check("reset_segments", 16'(segments), 16'h0);
        check("reset_digit_en", 16'(digit_en), 16'h0);
        check("reset_ready", 16'(ready), 16'h1);
        check("reset_frame_start", 16'(frame_start), 16'h0);
        repeat (hold) @(negedge clk);
        resetn    = 1'b1;
        m_t       = 0;
        m_pending = 1'b0;
        m_shadow  = '0;
        m_active  = '0;
        exp_q.delete();
    endtask

    // One clock: predict from current inputs, advance, compare at the following negedge.
    task automatic step();
        int          cnt;
        int          idx;
        bit          on;
        logic [6:0]  e_seg;
        logic [3:0]  e_en;
        logic        e_fs;
        bit          acc;
        bit          com;
        logic [12:0] exp_v;
        cnt = m_t % PRESCALE;
        idx = (m_t / PRESCALE) % DIGITS;
        on  = (cnt >= BLANK);
`ifdef SEVENSEG_SCAN_DIM_EN
        on  = on && ((cnt - BLANK) < (((PRESCALE - BLANK) * (int'(brightness) + 1)) / 16));
`endif
        e_seg = on ? m_active[7*idx +: 7] : 7'd0;
        e_en  = on ? 4'(1 << idx) : 4'd0;
        e_fs  = ((m_t % FRAME) == 0);
        acc   = load && !m_pending;
        com   = ((m_t % FRAME) == FRAME - 1) && m_pending;
        if (com) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        if (acc) begin
            m_shadow  = patterns;
            m_pending = 1'b1;
        end
        m_t++;
        exp_q.push_back({e_seg, e_en, e_fs, !m_pending});
        @(posedge clk);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        check("segments", 16'(segments), 16'(exp_v[12:6]));
        check("digit_en", 16'(digit_en), 16'(exp_v[5:2]));
        check("frame_start", 16'(frame_start), 16'(exp_v[1]));
        check("ready", 16'(ready), 16'(exp_v[0]));
        check("digit_en_onehot", 16'($countones(digit_en) <= 1), 16'h1);
        if (digit_en == 4'b0001 && segments == 7'h66) lit66++;
        if (digit_en == 4'b1000 && segments == 7'h06) lit06++;
        if (digit_en != 4'd0) lit_cnt++;
    endtask

    initial begin
        @(negedge clk);
        do_reset(2);

        // idle scanning: frame pulses every 32 cycles, blank patterns
        repeat (45) step();

        // mid-frame load, then a second load while not ready
        load     = 1'b1;
        patterns = {7'h06, 7'h5B, 7'h4F, 7'h66};
        step();
        check("ready_low_after_load", 16'(ready), 16'h0);
        patterns = {4{7'h7F}};
        step();
        step();
        load = 1'b0;
        while ((m_t % FRAME) != 0) step();
        lit66 = 0;
        lit06 = 0;
        repeat (FRAME) step();
        check("digit0_66_cycles", 16'(lit66), 16'd6);
        check("digit3_06_cycles", 16'(lit06), 16'd6);

        // load offered exactly on the commit cycle is refused; the next cycle accepts
        load     = 1'b1;
        patterns = 28'($urandom());
        step();
        load = 1'b0;
        while ((m_t % FRAME) != FRAME - 1) step();
        load     = 1'b1;
        patterns = 28'($urandom());
        step();
        check("ready_after_commit", 16'(ready), 16'h1);
        patterns = 28'($urandom());
        step();
        check("ready_after_accept", 16'(ready), 16'h0);
        load = 1'b0;
        repeat (2 * FRAME) step();

        // reset in the middle of a lit frame
        repeat (13) step();
        do_reset(3);
        repeat (40) step();

`ifdef SEVENSEG_SCAN_DIM_EN
        brightness = 4'd7;
        while ((m_t % PRESCALE) != 0) step();
        lit_cnt = 0;
        repeat (PRESCALE) step();
        check("dim_on_cycles", 16'(lit_cnt), 16'd3);
        brightness = 4'd15;
`endif

        // randomized traffic with occasional resets
        repeat (800) begin
            load     = ($urandom_range(0, 7) == 0);
            patterns = 28'($urandom());
`ifdef SEVENSEG_SCAN_DIM_EN
            brightness = 4'($urandom_range(0, 15));
`endif
            if ($urandom_range(0, 299) == 0) begin
                load = 1'b0;
                do_reset($urandom_range(1, 3));
            end
            step();
        end
        load = 1'b0;
        repeat (FRAME) step();
        check("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
